// File: rtl/pwm_capture_core.sv
// PWM input capture: measures period and high time of pwm_in in clk cycles,
// reporting each result as a one-cycle valid pulse with held result registers.
module pwm_capture_core #(
    parameter int unsigned counter_width_p = 16,
    parameter int unsigned sync_stages_p   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pwm_in,
    input  logic                       cr_enable,
    output logic                       meas_valid,
    output logic [counter_width_p-1:0] meas_period,
    output logic [counter_width_p-1:0] meas_high,
    output logic                       meas_timeout,
    output logic                       meas_level
);

    localparam logic [counter_width_p-1:0] CntMax = '1;
    localparam logic [counter_width_p-1:0] CntOne = counter_width_p'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_e;

    state_e                     state_q, state_d;
    logic [sync_stages_p-1:0]   sync_q;
    logic                       s_q;
    logic [counter_width_p-1:0] cnt_q, cnt_d;
    logic [counter_width_p-1:0] high_lat_q, high_lat_d;
    logic                       valid_q, valid_d;
    logic [counter_width_p-1:0] period_q, period_d;
    logic [counter_width_p-1:0] high_q, high_d;
    logic                       tmo_q, tmo_d;
    logic                       lvl_q, lvl_d;

    logic s, rise, fall, timeout;

    assign s       = sync_q[sync_stages_p-1];
    assign rise    = s & ~s_q;
    assign fall    = ~s & s_q;
    // A rise at the counter limit is a valid edge, so it takes precedence.
    assign timeout = (cnt_q == CntMax) && !rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            s_q        <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            high_lat_q <= '0;
            valid_q    <= 1'b0;
            period_q   <= '0;
            high_q     <= '0;
            tmo_q      <= 1'b0;
            lvl_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[sync_stages_p-2:0], pwm_in};
            s_q        <= s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_lat_q <= high_lat_d;
            valid_q    <= valid_d;
            period_q   <= period_d;
            high_q     <= high_d;
            tmo_q      <= tmo_d;
            lvl_q      <= lvl_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_lat_d = high_lat_q;
        valid_d    = 1'b0;
        period_d   = period_q;
        high_d     = high_q;
        tmo_d      = tmo_q;
        lvl_d      = lvl_q;

        if (!cr_enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (timeout) begin
            valid_d  = 1'b1;
            tmo_d    = 1'b1;
            period_d = CntMax;
            high_d   = s ? CntMax : '0;
            lvl_d    = s;
            cnt_d    = CntOne;
            state_d  = ST_IDLE;
        end else begin
            cnt_d = rise ? CntOne : cnt_q + CntOne;
            case (state_q)
                ST_IDLE: if (rise) state_d = ST_HIGH;
                ST_HIGH: begin
                    if (fall) begin
                        high_lat_d = cnt_q;
                        state_d    = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        valid_d  = 1'b1;
                        period_d = cnt_q;
                        high_d   = high_lat_q;
                        tmo_d    = 1'b0;
                        lvl_d    = 1'b0;
                        state_d  = ST_HIGH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign meas_valid   = valid_q;
    assign meas_period  = period_q;
    assign meas_high    = high_q;
    assign meas_timeout = tmo_q;
    assign meas_level   = lvl_q;

endmodule

// File: tb/tb_pwm_capture_core.sv
// Scoreboard bench for pwm_capture_core (8-bit counter, 2 sync stages):
// directed PWM waveforms push expected results; a monitor checks each valid.
module tb_pwm_capture_core;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         pwm_in;
    logic         cr_enable;
    logic         meas_valid;
    logic [W-1:0] meas_period;
    logic [W-1:0] meas_high;
    logic         meas_timeout;
    logic         meas_level;

    pwm_capture_core #(
        .counter_width_p(W),
        .sync_stages_p  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .cr_enable   (cr_enable),
        .meas_valid  (meas_valid),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .meas_timeout(meas_timeout),
        .meas_level  (meas_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] period;
        logic [W-1:0] high;
        logic         tmo;
        logic         lvl;
        int           gap;   // cycles since previous valid; 0 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cycle  = 0;
    int   last_valid = -1;

    task automatic push(input int p, input int h, input logic t, input logic l, input int g);
        exp_t e;
        e.period = W'(p);
        e.high   = W'(h);
        e.tmo    = t;
        e.lvl    = l;
        e.gap    = g;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input int h, input int l);
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic restart();
        cr_enable = 1'b0;
        repeat (5) @(negedge clk);
        cr_enable = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        cycle++;
        if (rst_n && meas_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: cycle %0d p=%0d h=%0d t=%0b l=%0b, expected no result",
                         cycle, meas_period, meas_high, meas_timeout, meas_level);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (meas_period !== e.period || meas_high !== e.high ||
                    meas_timeout !== e.tmo || meas_level !== e.lvl) begin
                    n_fail++;
                    $display("FAIL result: cycle %0d got p=%0d h=%0d t=%0b l=%0b, expected p=%0d h=%0d t=%0b l=%0b",
                             cycle, meas_period, meas_high, meas_timeout, meas_level,
                             e.period, e.high, e.tmo, e.lvl);
                end
                if (e.gap != 0) begin
                    n_cmp++;
                    if (cycle - last_valid != e.gap) begin
                        n_fail++;
                        $display("FAIL valid_gap: got %0d cycles, expected %0d", cycle - last_valid, e.gap);
                    end
                end
            end
            last_valid = cycle;
        end
    end

    initial begin
        rst_n     = 1'b0;
        pwm_in    = 1'b0;
        cr_enable = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_valid",  int'(meas_valid),   0);
        check("reset_period", int'(meas_period),  0);
        check("reset_high",   int'(meas_high),    0);
        check("reset_tmo",    int'(meas_timeout), 0);
        check("reset_level",  int'(meas_level),   0);
        rst_n = 1'b1;
        restart();

        // Steady PWM, period 200, duty 64 then 150
        pulse(64, 136);
        push(200, 64, 1'b0, 1'b0, 0);    pulse(64, 136);
        push(200, 64, 1'b0, 1'b0, 200);  pulse(150, 50);
        push(200, 150, 1'b0, 1'b0, 200); pulse(150, 50);
        push(200, 150, 1'b0, 1'b0, 200); pulse(150, 50);
        restart();

        // Single-cycle high pulse every 10 cycles
        pulse(1, 9);
        push(10, 1, 1'b0, 1'b0, 0);  pulse(1, 9);
        push(10, 1, 1'b0, 1'b0, 10); pulse(1, 9);
        push(10, 1, 1'b0, 1'b0, 10); pulse(1, 9);
        restart();

        // Boundary: period 255 is a result, period 256 times out in LOW
        pulse(100, 155);
        push(255, 100, 1'b0, 1'b0, 0);
        pulse(100, 155);
        push(255, 100, 1'b0, 1'b0, 255);
        push(255, 0, 1'b1, 1'b0, 255);
        pulse(100, 156);
        pulse(100, 155);
        push(255, 100, 1'b0, 1'b0, 256);
        pulse(100, 155);
        restart();

        // Stuck high, then stuck low: timeout every 255 cycles
        push(255, 255, 1'b1, 1'b1, 0);
        push(255, 255, 1'b1, 1'b1, 255);
        push(255, 0, 1'b1, 1'b0, 255);
        push(255, 0, 1'b1, 1'b0, 255);
        pulse(600, 450);
        restart();

        // Disable during HIGH: no result, held outputs, restart needs two rises
        pulse(50, 50);
        push(100, 50, 1'b0, 1'b0, 0);   pulse(50, 50);
        push(100, 50, 1'b0, 1'b0, 100);
        pwm_in = 1'b1;
        repeat (20) @(negedge clk);
        cr_enable = 1'b0;
        repeat (5) @(negedge clk);
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        check("hold_valid",  int'(meas_valid),   0);
        check("hold_period", int'(meas_period),  100);
        check("hold_high",   int'(meas_high),    50);
        check("hold_tmo",    int'(meas_timeout), 0);
        check("hold_level",  int'(meas_level),   0);
        cr_enable = 1'b1;
        repeat (3) @(negedge clk);
        pulse(40, 60);
        push(100, 40, 1'b0, 1'b0, 0);   pulse(40, 60);

        // Async reset during HIGH, released with the input still high
        push(100, 40, 1'b0, 1'b0, 100);
        pwm_in = 1'b1;
        repeat (10) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid",  int'(meas_valid),   0);
        check("arst_period", int'(meas_period),  0);
        check("arst_high",   int'(meas_high),    0);
        check("arst_tmo",    int'(meas_timeout), 0);
        check("arst_level",  int'(meas_level),   0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        pwm_in = 1'b0;
        repeat (70) @(negedge clk);
        push(100, 30, 1'b0, 1'b0, 0);
        pulse(30, 70);

        cr_enable = 1'b0;
        repeat (10) @(negedge clk);
        check("pending_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
